// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer: FSM state encoding,
// default filter length and the counter width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam int DEFAULT_STABLE_CYCLES = 4;
    localparam int MIN_STABLE_CYCLES     = 2;
    localparam int MAX_STABLE_CYCLES     = 255;

    // Counter must hold 0..STABLE_CYCLES-1; sized with one value of headroom.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw switch level into the clk domain.
// Both stages clear to 0 under the asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/input_debouncer.sv
// Switch debouncer: synchronizes A, then accepts a level change only after
// STABLE_CYCLES consecutive identical samples, with one-cycle rise/fall pulses.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   A,
    output logic                                   Z,
    output logic                                   rise,
    output logic                                   fall,
    output state_t                                 o_dbg_state,
    output logic [$clog2(STABLE_CYCLES+1)-1:0]     o_dbg_cnt
);

    localparam int                CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < MIN_STABLE_CYCLES || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_param
        $error("input_debouncer: STABLE_CYCLES=%0d outside 2..255", STABLE_CYCLES);
    end

    logic          w_s_q;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_z;
    logic          r_rise;
    logic          r_fall;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (A),
        .q     (w_s_q)
    );

    // Pulses default low every cycle, so each accepted change yields exactly one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_z     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (w_s_q) begin
                        r_state <= WAIT_HI;
                        r_cnt   <= CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!w_s_q) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_z     <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!w_s_q) begin
                        r_state <= WAIT_LO;
                        r_cnt   <= CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (w_s_q) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        r_z     <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign Z           = r_z;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed + randomized bench for input_debouncer; accepted changes are queued
// as {rise,fall,cycle} when A is driven and matched when pulses appear.
module tb_input_debouncer;
    import debounce_pkg::*;

    localparam int SC = 4;
    localparam int CW = $clog2(SC + 1);

    logic          clk;
    logic          rst_n;
    logic          A;
    logic          Z;
    logic          rise;
    logic          fall;
    state_t        dbg_state;
    logic [CW-1:0] dbg_cnt;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [31:0]   cyc      = 0;
    logic [33:0]   exp_q[$];
    int            n_pushed = 0;
    int            n_pulses = 0;

    input_debouncer #(.STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .A           (A),
        .Z           (Z),
        .rise        (rise),
        .fall        (fall),
        .o_dbg_state (dbg_state),
        .o_dbg_cnt   (dbg_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Accepted change: first sync sample at the next edge, Z updates SC+2 edges later.
    task automatic push_event(input logic is_rise);
        exp_q.push_back({is_rise, ~is_rise, cyc + 32'(SC + 2)});
        n_pushed++;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_z"}, 64'(Z), 64'(0));
        chk({tag, "_rise"}, 64'(rise), 64'(0));
        chk({tag, "_fall"}, 64'(fall), 64'(0));
    endtask

    // Monitor samples mid-cycle, away from both clock edges.
    initial begin
        logic        z_prev;
        logic        prev_pulse;
        logic [33:0] e;
        z_prev     = 1'b0;
        prev_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                z_prev     = 1'b0;
                prev_pulse = 1'b0;
            end else begin
                chk("cnt_bound", 64'(dbg_cnt <= CW'(SC - 1)), 64'(1));
                if ((Z !== z_prev) || rise || fall)
                    chk("z_vs_pulse", 64'({rise, fall}),
                        64'((Z !== z_prev) ? (Z ? 2'b10 : 2'b01) : 2'b00));
                if (rise || fall) begin
                    n_pulses++;
                    chk("pulse_width", 64'(prev_pulse), 64'(0));
                    chk("pulse_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("event", 64'({rise, fall, cyc}), 64'(e));
                    end
                end
                z_prev     = Z;
                prev_pulse = rise | fall;
            end
        end
    end

    initial begin
        logic lvl;
        logic zm;
        int   used;
        int   len;

        rst_n = 1'b1;
        A     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("reset");
        chk("reset_state", 64'(dbg_state), 64'(STABLE_LO));
        chk("reset_cnt", 64'(dbg_cnt), 64'(0));
        step(3);
        rst_n = 1'b1;

        // Quiet input for 200 cycles
        step(200);
        chk_idle_outputs("quiet");

        // Clean 0->1 held high
        A = 1'b1;
        push_event(1'b1);
        step(5);
        chk("rise_lat_before_z", 64'(Z), 64'(0));
        chk("rise_lat_before_rise", 64'(rise), 64'(0));
        step(1);
        chk("rise_lat_z", 64'(Z), 64'(1));
        chk("rise_lat_rise", 64'(rise), 64'(1));
        chk("rise_lat_fall", 64'(fall), 64'(0));
        step(1);
        chk("rise_one_cycle", 64'(rise), 64'(0));
        chk("rise_hold_z", 64'(Z), 64'(1));
        step(20);
        chk("held_high_state", 64'(dbg_state), 64'(STABLE_HI));

        // Bounce then settle low
        A = 1'b0; step(1);
        A = 1'b1; step(1);
        A = 1'b0; step(1);
        A = 1'b1; step(1);
        A = 1'b0;
        push_event(1'b0);
        step(5);
        chk("fall_lat_before_z", 64'(Z), 64'(1));
        step(1);
        chk("fall_lat_z", 64'(Z), 64'(0));
        chk("fall_lat_fall", 64'(fall), 64'(1));
        chk("fall_lat_rise", 64'(rise), 64'(0));
        step(1);
        chk("fall_one_cycle", 64'(fall), 64'(0));
        step(10);

        // Short pulse rejected (SC-1 clocks)
        A = 1'b1; step(SC - 1);
        A = 1'b0; step(12);
        chk_idle_outputs("glitch");
        chk("glitch_state", 64'(dbg_state), 64'(STABLE_LO));

        // Exactly SC clocks high is accepted, then SC low accepted
        A = 1'b1; push_event(1'b1); step(SC);
        A = 1'b0; push_event(1'b0); step(12);
        chk("boundary_z", 64'(Z), 64'(0));

        // Reset in the middle of a count, A held high through release
        A = 1'b1;
        step(4);
        chk("mid_count_cnt", 64'(dbg_cnt), 64'(2));
        chk("mid_count_state", 64'(dbg_state), 64'(WAIT_HI));
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_reset");
        chk("mid_reset_cnt", 64'(dbg_cnt), 64'(0));
        chk("mid_reset_state", 64'(dbg_state), 64'(STABLE_LO));
        step(3);
        rst_n = 1'b1;
        push_event(1'b1);
        step(5);
        chk("rerise_before_z", 64'(Z), 64'(0));
        step(1);
        chk("rerise_z", 64'(Z), 64'(1));
        chk("rerise_rise", 64'(rise), 64'(1));
        step(5);

        // Asynchronous reset with Z high clears outputs without a clock edge
        rst_n = 1'b0;
        #1;
        chk("async_reset_z", 64'(Z), 64'(0));
        A = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(10);
        chk_idle_outputs("post_async");

        // Randomized runs; each run of a new level lasting >= SC is accepted
        lvl  = 1'b0;
        zm   = 1'b0;
        used = 0;
        while (used < 10000) begin
            lvl = ~lvl;
            len = $urandom_range(1, 8);
            A   = lvl;
            if (lvl != zm && len >= SC) begin
                push_event(lvl);
                zm = lvl;
            end
            step(len);
            used += len;
        end
        A = zm;
        step(12);
        chk("rand_final_z", 64'(Z), 64'(zm));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        chk("accepted_count", 64'(n_pulses), 64'(n_pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the number of consecutive identical synchronized samples required to accept a level change; legal range 2..255.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port A, input, 1 bit, SHALL be the raw, asynchronous, possibly bouncing switch input.
REQ-005 Port Z, output, 1 bit, SHALL be the registered, debounced level that feeds the downstream gate input.
REQ-006 Port rise, output, 1 bit, SHALL be a registered one-cycle pulse marking each accepted 0->1 change of Z.
REQ-007 Port fall, output, 1 bit, SHALL be a registered one-cycle pulse marking each accepted 1->0 change of Z.

Function
REQ-008 A SHALL pass through a 2-flop synchronizer; its output is s_q, which lags A by 2 clk edges.
REQ-009 The FSM SHALL have four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-010 In STABLE_LO with s_q=1, the FSM SHALL go to WAIT_HI and load cnt=1; with s_q=0 it SHALL hold.
REQ-011 In WAIT_HI with s_q=0, the FSM SHALL return to STABLE_LO, clear cnt and leave Z, rise and fall unchanged (glitch rejected).
REQ-012 In WAIT_HI with s_q=1 and cnt=STABLE_CYCLES-1, the FSM SHALL go to STABLE_HI, set Z=1 and assert rise for exactly one cycle; otherwise it SHALL increment cnt.
REQ-013 STABLE_HI and WAIT_LO SHALL mirror REQ-010..012 with polarity inverted, setting Z=0 and pulsing fall.
REQ-014 Latency: if edge 1 is the first edge at which A is sampled high and A then stays high, Z SHALL be 1 after edge STABLE_CYCLES+2 (edge 6 at default).
REQ-015 cnt SHALL be $clog2(STABLE_CYCLES+1) bits wide and SHALL never exceed STABLE_CYCLES-1.
REQ-016 rise and fall SHALL never be asserted in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-017 A pulse on A shorter than STABLE_CYCLES clocks, as seen at s_q, SHALL produce no change on Z, rise or fall.
REQ-018 A held constant for any duration SHALL produce no further pulses after the first accepted change.
REQ-019 An out-of-range STABLE_CYCLES SHALL cause an elaboration-time error.

Reset
REQ-020 When rst_n is low, the synchronizer flops SHALL be 0, the state SHALL be STABLE_LO, cnt SHALL be 0, and Z, rise and fall SHALL be 0, independent of clk.
REQ-021 Reset asserted mid-count SHALL discard the partial count; after release, a high A SHALL need the full REQ-014 latency again.
REQ-022 If A is already high at reset release, Z SHALL rise after STABLE_CYCLES+2 edges with one rise pulse.

Structure
REQ-023 The state enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO) and the constant DEFAULT_STABLE_CYCLES=4 SHALL live in the shared package debounce_pkg.
REQ-024 The synchronizer SHALL be a separate sub-module sync_2ff (ports clk, rst_n, d, q), instantiated once.
REQ-025 Z, rise and fall SHALL be driven directly from flops, with no combinational path from A to any output.

Verification (STABLE_CYCLES=4, clk period 10)
REQ-026 Reset then A=0 for 200 -> Z, rise and fall remain 0 throughout.
REQ-027 A 0->1 sampled at edge 1 and held -> Z=1 after edge 6; rise=1 only in the cycle after edge 6; fall stays 0.
REQ-028 A high for 3 clocks, then low -> Z stays 0 and no pulses occur.
REQ-029 With Z=1, A bounces 1,0,1,0 each clock then settles at 0 -> Z=0 exactly 6 edges after the first stable-0 sample, with a single fall pulse.
REQ-030 rst_n pulled low at the edge where cnt=2 in WAIT_HI, then released with A held high -> all outputs 0 asynchronously, Z rises 6 edges after release, one rise pulse.
REQ-031 Randomized A toggling across 10000 cycles -> rise/fall exclusivity, one-cycle pulse width, and Z changes matching the accepted-change count.
